// File: rtl/alu_operand_stage.sv
// ALU operand stage: builds a/b/aluc from decoded fields with EX/MEM and MEM/WB forwarding,
// then buffers the result in a 2-entry skid FIFO whose head registers drive out_* directly.
module alu_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [15:0]       in_imm,
    input  logic [4:0]        in_sa,
    input  logic [3:0]        in_aluc,
    input  logic              in_aluimm,
    input  logic              in_sext,
    input  logic              in_shift,
    input  logic              in_wreg,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              exm_wreg,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              mwb_wreg,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [3:0]        out_aluc,
    output logic              out_wreg,
    output logic [REG_AW-1:0] out_rd_addr
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        aluc;
        logic              wreg;
        logic [REG_AW-1:0] rd;
    } entry_t;

    logic [1:0] count_q, count_d;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    entry_t     new_entry;

    logic exm_hit_rs, mwb_hit_rs, exm_hit_rt, mwb_hit_rt;
    logic [DATA_W-1:0] rsv, rtv, imm_ext;
    logic push, pop;

    // Address 0 is the hardwired zero register and never forwards.
    always_comb begin
        exm_hit_rs = FWD_EN && exm_wreg && (exm_rd == in_rs_addr) && (in_rs_addr != '0);
        mwb_hit_rs = FWD_EN && mwb_wreg && (mwb_rd == in_rs_addr) && (in_rs_addr != '0);
        exm_hit_rt = FWD_EN && exm_wreg && (exm_rd == in_rt_addr) && (in_rt_addr != '0);
        mwb_hit_rt = FWD_EN && mwb_wreg && (mwb_rd == in_rt_addr) && (in_rt_addr != '0);

        rsv = exm_hit_rs ? exm_data : (mwb_hit_rs ? mwb_data : in_rs_data);
        rtv = exm_hit_rt ? exm_data : (mwb_hit_rt ? mwb_data : in_rt_data);

        imm_ext = in_sext ? {{(DATA_W-16){in_imm[15]}}, in_imm} : {{(DATA_W-16){1'b0}}, in_imm};

        new_entry.a    = in_shift ? DATA_W'(in_sa) : rsv;
        new_entry.b    = in_aluimm ? imm_ext : rtv;
        new_entry.aluc = in_aluc;
        new_entry.wreg = in_wreg;
        new_entry.rd   = in_rd_addr;
    end

    assign in_ready  = !reset && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = new_entry;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = new_entry;
                    end else if (push) begin
                        tail_d  = new_entry;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = 2'd1;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign out_a       = head_q.a;
    assign out_b       = head_q.b;
    assign out_aluc    = head_q.aluc;
    assign out_wreg    = head_q.wreg;
    assign out_rd_addr = head_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: operand build, forwarding priority, skid buffering, flush.
module tb_alu_operand_stage;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] in_rs_data, in_rt_data;
    logic [4:0]  in_rs_addr, in_rt_addr;
    logic [15:0] in_imm;
    logic [4:0]  in_sa;
    logic [3:0]  in_aluc;
    logic        in_aluimm, in_sext, in_shift, in_wreg;
    logic [4:0]  in_rd_addr;
    logic        exm_wreg, mwb_wreg;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_data, mwb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b;
    logic [3:0]  out_aluc;
    logic        out_wreg;
    logic [4:0]  out_rd_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    alu_operand_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_imm(in_imm), .in_sa(in_sa), .in_aluc(in_aluc),
        .in_aluimm(in_aluimm), .in_sext(in_sext), .in_shift(in_shift),
        .in_wreg(in_wreg), .in_rd_addr(in_rd_addr),
        .exm_wreg(exm_wreg), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wreg(mwb_wreg), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_aluc(out_aluc),
        .out_wreg(out_wreg), .out_rd_addr(out_rd_addr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_rs_data = '0; in_rt_data = '0; in_rs_addr = '0; in_rt_addr = '0;
        in_imm = '0; in_sa = '0; in_aluc = '0; in_aluimm = 1'b0; in_sext = 1'b0;
        in_shift = 1'b0; in_wreg = 1'b0; in_rd_addr = '0;
        exm_wreg = 1'b0; exm_rd = '0; exm_data = '0;
        mwb_wreg = 1'b0; mwb_rd = '0; mwb_data = '0;

        // Reset held two cycles
        step(); step();
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_a", out_a, 32'd0);
        check_val("rst_b", out_b, 32'd0);
        check_val("rst_aluc", 32'(out_aluc), 32'd0);
        check_val("rst_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_val("rel_ready", 32'(in_ready), 32'd1);

        // Immediate sign / zero extension
        in_valid = 1'b1; in_aluimm = 1'b1; in_sext = 1'b1; in_imm = 16'h8000;
        in_rs_addr = 5'd1; in_rs_data = 32'd5;
        step();
        check_val("sext_valid", 32'(out_valid), 32'd1);
        check_val("sext_a", out_a, 32'd5);
        check_val("sext_b", out_b, 32'hFFFF8000);
        in_sext = 1'b0;
        step();
        check_val("zext_b", out_b, 32'h00008000);
        in_valid = 1'b0;
        step();
        check_val("drain_valid", 32'(out_valid), 32'd0);

        // Forwarding priority on rs and rt
        in_valid = 1'b1; in_aluimm = 1'b0; in_rs_data = 32'd1; in_rt_data = 32'd2;
        in_rs_addr = 5'd3; in_rt_addr = 5'd3;
        exm_wreg = 1'b1; exm_rd = 5'd3; exm_data = 32'd7;
        mwb_wreg = 1'b1; mwb_rd = 5'd3; mwb_data = 32'd9;
        step();
        check_val("fwd_exm_a", out_a, 32'd7);
        check_val("fwd_exm_b", out_b, 32'd7);
        exm_wreg = 1'b0;
        step();
        check_val("fwd_mwb_a", out_a, 32'd9);
        check_val("fwd_mwb_b", out_b, 32'd9);
        exm_wreg = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
        in_rs_addr = 5'd0; in_rt_addr = 5'd0; in_rs_data = 32'h55; in_rt_data = 32'h66;
        step();
        check_val("fwd_zero_a", out_a, 32'h55);
        check_val("fwd_zero_b", out_b, 32'h66);

        // Shift amount path and passthrough fields
        exm_wreg = 1'b0; mwb_wreg = 1'b0;
        in_shift = 1'b1; in_sa = 5'd31; in_aluc = 4'hF; in_rt_addr = 5'd2;
        in_rt_data = 32'h80000000; in_wreg = 1'b1; in_rd_addr = 5'd7;
        step();
        check_val("sh_a", out_a, 32'd31);
        check_val("sh_b", out_b, 32'h80000000);
        check_val("sh_aluc", 32'(out_aluc), 32'hF);
        check_val("sh_wreg", 32'(out_wreg), 32'd1);
        check_val("sh_rd", 32'(out_rd_addr), 32'd7);
        in_valid = 1'b0; in_shift = 1'b0; in_aluc = 4'h0; in_wreg = 1'b0; in_rd_addr = 5'd0;
        step();
        check_val("sh_drain", 32'(out_valid), 32'd0);

        // Stall and skid ordering
        out_ready = 1'b0; in_valid = 1'b1; in_rs_addr = 5'd1; in_rs_data = 32'hA1;
        step();
        check_val("sk_a_head", out_a, 32'hA1);
        check_val("sk_ready1", 32'(in_ready), 32'd1);
        in_rs_data = 32'hB2;
        step();
        check_val("sk_full_ready", 32'(in_ready), 32'd0);
        check_val("sk_hold_a", out_a, 32'hA1);
        in_valid = 1'b0;
        step();
        check_val("sk_stall_a", out_a, 32'hA1);
        check_val("sk_stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        check_val("sk_b_head", out_a, 32'hB2);
        check_val("sk_b_valid", 32'(out_valid), 32'd1);
        check_val("sk_b_ready", 32'(in_ready), 32'd1);
        step();
        check_val("sk_empty", 32'(out_valid), 32'd0);

        // Flush with full buffer and a pending push
        out_ready = 1'b0; in_valid = 1'b1; in_rs_data = 32'hC3;
        step(); step();
        check_val("fl_full", 32'(in_ready), 32'd0);
        flush = 1'b1; out_ready = 1'b1; in_rs_data = 32'hD4;
        step();
        check_val("fl_valid", 32'(out_valid), 32'd0);
        check_val("fl_ready", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check_val("fl_dropped", 32'(out_valid), 32'd0);

        // Reset mid-stream zeroes payload
        in_valid = 1'b1; in_rs_data = 32'hE5;
        step();
        check_val("mr_push", out_a, 32'hE5);
        in_valid = 1'b0; reset = 1'b1;
        step();
        check_val("mr_valid", 32'(out_valid), 32'd0);
        check_val("mr_a", out_a, 32'd0);
        check_val("mr_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
